// File: rtl/data_mem_stage_pkg.sv
// Shared CPU definitions: memory opcodes, data memory depth and pipeline reset value.
package data_mem_stage_pkg;

  localparam int          DM_WORDS_DEF = 3072;
  localparam logic [31:0] INIT_DEF     = 32'h0000_0000;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_e;

endpackage

// File: rtl/dm_access_unit.sv
// Combinational decode of memory opcodes: fault detection, store byte enables and
// write data, and load lane selection with sign/zero extension.
module dm_access_unit
  import data_mem_stage_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic        in_range_i,
  input  logic [31:0] rd2_i,
  input  logic [31:0] rd_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        fault_o
);

  logic      is_load, is_store, is_signed, misaligned;
  acc_size_e size;
  logic [31:0] byte_sh, half_sh;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = SZ_W;
    case (op_i)
      OP_LB:   begin is_load  = 1'b1; size = SZ_B; is_signed = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; size = SZ_B; end
      OP_LH:   begin is_load  = 1'b1; size = SZ_H; is_signed = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; size = SZ_H; end
      OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
      OP_SB:   begin is_store = 1'b1; size = SZ_B; end
      OP_SH:   begin is_store = 1'b1; size = SZ_H; end
      OP_SW:   begin is_store = 1'b1; size = SZ_W; end
      default: ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (size == SZ_W) misaligned = (lane_i != 2'b00);
    else if (size == SZ_H) misaligned = lane_i[0];
    fault_o = (is_load | is_store) & (misaligned | ~in_range_i);
  end

  // Faulting stores produce no enables, so the array never sees them.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = rd2_i;
    case (size)
      SZ_B:    wdata_o = {4{rd2_i[7:0]}};
      SZ_H:    wdata_o = {2{rd2_i[15:0]}};
      default: wdata_o = rd2_i;
    endcase
    if (is_store && !fault_o) begin
      case (size)
        SZ_B:    be_o = 4'(4'b0001 << lane_i);
        SZ_H:    be_o = 4'(4'b0011 << lane_i);
        default: be_o = 4'b1111;
      endcase
    end
  end

  assign byte_sh = rd_word_i >> {lane_i, 3'b000};
  assign half_sh = rd_word_i >> {lane_i[1], 4'b0000};

  always_comb begin
    load_data_o = 32'h0;
    if (is_load && !fault_o) begin
      case (size)
        SZ_B:    load_data_o = {{24{is_signed & byte_sh[7]}}, byte_sh[7:0]};
        SZ_H:    load_data_o = {{16{is_signed & half_sh[15]}}, half_sh[15:0]};
        default: load_data_o = rd_word_i;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// MEM pipeline stage: byte-addressable data memory plus the MEM/WB register.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int          DM_WORDS = DM_WORDS_DEF,
  parameter logic [31:0] INIT     = INIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_pc_4,
  input  logic [31:0] mem_ir,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_rd2,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_pc_4,
  output logic [31:0] wb_ir,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic        wb_fault
);

  localparam int          IDX_W    = $clog2(DM_WORDS);
  localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

  logic [31:0] dm_q [DM_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic [31:0]      rd_word, wdata, mem_data_d;
  logic [3:0]       be;
  logic             fault_d;

  logic [31:0] wb_pc_q, wb_pc_4_q, wb_ir_q, wb_alu_out_q, wb_mem_data_q;
  logic        wb_fault_q;

  assign word_idx = mem_alu_out[IDX_W+1:2];
  assign in_range = (mem_alu_out < DM_BYTES);
  // Range gate keeps out-of-range indices from touching the array.
  assign rd_word  = in_range ? dm_q[word_idx] : 32'h0;

  dm_access_unit u_access (
    .op_i        (mem_ir[31:26]),
    .lane_i      (mem_alu_out[1:0]),
    .in_range_i  (in_range),
    .rd2_i       (mem_rd2),
    .rd_word_i   (rd_word),
    .be_o        (be),
    .wdata_o     (wdata),
    .load_data_o (mem_data_d),
    .fault_o     (fault_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) dm_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_pc_q       <= INIT;
      wb_pc_4_q     <= INIT;
      wb_ir_q       <= INIT;
      wb_alu_out_q  <= INIT;
      wb_mem_data_q <= INIT;
      wb_fault_q    <= 1'b0;
    end else begin
      wb_pc_q       <= mem_pc;
      wb_pc_4_q     <= mem_pc_4;
      wb_ir_q       <= mem_ir;
      wb_alu_out_q  <= mem_alu_out;
      wb_mem_data_q <= mem_data_d;
      wb_fault_q    <= fault_d;
    end
  end

  assign wb_pc       = wb_pc_q;
  assign wb_pc_4     = wb_pc_4_q;
  assign wb_ir       = wb_ir_q;
  assign wb_alu_out  = wb_alu_out_q;
  assign wb_mem_data = wb_mem_data_q;
  assign wb_fault    = wb_fault_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: stores, extended loads, faults, reset and pass-through.
module tb_data_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_pc, mem_pc_4, mem_ir, mem_alu_out, mem_rd2;
  logic [31:0] wb_pc, wb_pc_4, wb_ir, wb_alu_out, wb_mem_data;
  logic        wb_fault;

  int tests = 0;
  int fails = 0;
  logic [31:0] pc = 32'h0040_0000;

  localparam logic [31:0] I_LW   = 32'h8C00_0000;
  localparam logic [31:0] I_LB   = 32'h8000_0000;
  localparam logic [31:0] I_LBU  = 32'h9000_0000;
  localparam logic [31:0] I_LH   = 32'h8400_0000;
  localparam logic [31:0] I_LHU  = 32'h9400_0000;
  localparam logic [31:0] I_SW   = 32'hAC00_0000;
  localparam logic [31:0] I_SB   = 32'hA000_0000;
  localparam logic [31:0] I_SH   = 32'hA400_0000;
  localparam logic [31:0] I_ADDU = 32'h0085_1021;

  data_mem_stage dut (
    .clk         (clk),
    .reset       (reset),
    .mem_pc      (mem_pc),
    .mem_pc_4    (mem_pc_4),
    .mem_ir      (mem_ir),
    .mem_alu_out (mem_alu_out),
    .mem_rd2     (mem_rd2),
    .wb_pc       (wb_pc),
    .wb_pc_4     (wb_pc_4),
    .wb_ir       (wb_ir),
    .wb_alu_out  (wb_alu_out),
    .wb_mem_data (wb_mem_data),
    .wb_fault    (wb_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction in MEM, then sample the WB register just after the edge.
  task automatic step(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_ir      = ir;
    mem_alu_out = addr;
    mem_rd2     = data;
    mem_pc      = pc;
    mem_pc_4    = pc + 32'd4;
    pc          = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_pc = '0; mem_pc_4 = '0; mem_ir = '0; mem_alu_out = '0; mem_rd2 = '0;
    step(I_SW, 32'h0000_0010, 32'hFFFF_FFFF);
    step(I_SW, 32'h0000_0010, 32'hFFFF_FFFF);
    chk("rst_pc",       wb_pc,       32'h0);
    chk("rst_pc4",      wb_pc_4,     32'h0);
    chk("rst_ir",       wb_ir,       32'h0);
    chk("rst_alu",      wb_alu_out,  32'h0);
    chk("rst_data",     wb_mem_data, 32'h0);
    chk("rst_fault",    {31'h0, wb_fault}, 32'h0);
    reset = 1'b0;

    // First edge after reset captures normally; store during reset was dropped.
    step(I_LW, 32'h0000_0010, 32'h0);
    chk("post_rst_lw",  wb_mem_data, 32'h0);
    chk("post_rst_pc",  wb_pc,       pc - 32'd4);
    chk("post_rst_pc4", wb_pc_4,     pc);
    chk("post_rst_ir",  wb_ir,       I_LW);

    step(I_SW, 32'h0000_0008, 32'h1234_5678);
    chk("sw_fault",     {31'h0, wb_fault}, 32'h0);
    chk("sw_data",      wb_mem_data, 32'h0);
    step(I_LW, 32'h0000_0008, 32'h0);
    chk("lw_8",         wb_mem_data, 32'h1234_5678);
    chk("lw_8_fault",   {31'h0, wb_fault}, 32'h0);
    chk("lw_8_alu",     wb_alu_out,  32'h0000_0008);

    step(I_SB, 32'h0000_0009, 32'h0000_00AB);
    step(I_LB, 32'h0000_0009, 32'h0);
    chk("lb_9",         wb_mem_data, 32'hFFFF_FFAB);
    step(I_LBU, 32'h0000_0009, 32'h0);
    chk("lbu_9",        wb_mem_data, 32'h0000_00AB);
    step(I_LW, 32'h0000_0008, 32'h0);
    chk("lw_after_sb",  wb_mem_data, 32'h1234_AB78);
    step(I_LBU, 32'h0000_000B, 32'h0);
    chk("lbu_b",        wb_mem_data, 32'h0000_0012);

    step(I_SH, 32'h0000_000A, 32'h0000_8001);
    step(I_LH, 32'h0000_000A, 32'h0);
    chk("lh_a",         wb_mem_data, 32'hFFFF_8001);
    step(I_LHU, 32'h0000_000A, 32'h0);
    chk("lhu_a",        wb_mem_data, 32'h0000_8001);
    step(I_LH, 32'h0000_0008, 32'h0);
    chk("lh_8",         wb_mem_data, 32'hFFFF_AB78);
    step(I_LW, 32'h0000_0008, 32'h0);
    chk("lw_after_sh",  wb_mem_data, 32'h8001_AB78);

    step(I_LW, 32'h0000_0006, 32'h0);
    chk("lw6_fault",    {31'h0, wb_fault}, 32'h1);
    chk("lw6_data",     wb_mem_data, 32'h0);
    step(I_LHU, 32'h0000_0009, 32'h0);
    chk("lhu9_fault",   {31'h0, wb_fault}, 32'h1);
    chk("lhu9_data",    wb_mem_data, 32'h0);

    step(I_SH, 32'h0000_0003, 32'h0000_FFFF);
    chk("sh3_fault",    {31'h0, wb_fault}, 32'h1);
    step(I_LW, 32'h0000_0000, 32'h0);
    chk("sh3_nowrite",  wb_mem_data, 32'h0);
    chk("fault_1cyc",   {31'h0, wb_fault}, 32'h0);

    step(I_SW, 32'h0000_2FFC, 32'h55AA_0FF0);
    chk("sw_top_fault", {31'h0, wb_fault}, 32'h0);
    step(I_LW, 32'h0000_2FFC, 32'h0);
    chk("lw_top",       wb_mem_data, 32'h55AA_0FF0);
    step(I_SW, 32'h0000_3000, 32'hCAFE_BABE);
    chk("sw3000_fault", {31'h0, wb_fault}, 32'h1);
    step(I_LW, 32'h0000_0000, 32'h0);
    chk("sw3000_nowrap", wb_mem_data, 32'h0);
    step(I_LB, 32'h0000_3000, 32'h0);
    chk("lb3000_fault", {31'h0, wb_fault}, 32'h1);
    chk("lb3000_data",  wb_mem_data, 32'h0);
    step(I_LBU, 32'h0000_2FFF, 32'h0);
    chk("lbu_2fff",     wb_mem_data, 32'h0000_0055);

    step(I_ADDU, 32'hDEAD_BEEF, 32'h0000_0008);
    chk("addu_alu",     wb_alu_out,  32'hDEAD_BEEF);
    chk("addu_ir",      wb_ir,       I_ADDU);
    chk("addu_data",    wb_mem_data, 32'h0);
    chk("addu_fault",   {31'h0, wb_fault}, 32'h0);
    step(I_LW, 32'h0000_0008, 32'h0);
    chk("addu_nowrite", wb_mem_data, 32'h8001_AB78);

    // Reset in the middle of the run with a store pending.
    reset = 1'b1;
    step(I_SW, 32'h0000_0020, 32'h0000_0777);
    chk("mid_rst_pc",   wb_pc,       32'h0);
    chk("mid_rst_ir",   wb_ir,       32'h0);
    chk("mid_rst_alu",  wb_alu_out,  32'h0);
    chk("mid_rst_data", wb_mem_data, 32'h0);
    reset = 1'b0;
    step(I_LW, 32'h0000_0020, 32'h0);
    chk("mid_rst_drop", wb_mem_data, 32'h0);
    step(I_LW, 32'h0000_0008, 32'h0);
    chk("mid_rst_clr",  wb_mem_data, 32'h0);
    step(I_LW, 32'h0000_2FFC, 32'h0);
    chk("mid_rst_top",  wb_mem_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
